pixel_pack_fifo: RTL and testbench
==================================

Name: pixel_pack_fifo

Overview:
- Single-clock, parametrised successor to the 8-bit-write / 32-bit-read asymmetric pixel buffer.
- Accepts a stream of narrow pixels and packs RATIO consecutive pixels into one wide word, first pixel in the LSB lane.
- Buffers packed words in a DEPTH-entry FIFO and presents them on a valid/ready read port.
- Adds end-of-line flush (partial words carry a lane-keep mask), backpressure on both sides and an occupancy count. Sits between the pixel source and line/window processing stages.

Parameters:
- PIX_W, 8, pixel width in bits.
- RATIO, 4, pixels per packed word; must be at least 2.
- DEPTH, 16, FIFO depth in packed words; must be a power of 2 and at least 2.
- ADDR_W, log2(DEPTH), derived; not to be overridden.

Ports:
- clka  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid and s_ready are both high at a rising edge.
- s_data  in  PIX_W  input pixel.
- s_last  in  1  marks the final pixel of a line; qualified by s_valid.
- m_valid  out  1  head word available.
- m_ready  in  1  consumer takes the head word when m_valid and m_ready are both high at a rising edge.
- m_data  out  PIX_W*RATIO  packed word; lane k occupies bits [k*PIX_W +: PIX_W].
- m_keep  out  RATIO  per-lane valid mask for m_data.
- m_last  out  1  head word ends a line.
- count  out  ADDR_W+1  number of words held in the FIFO, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - write/read pointers = 0, lane index = 0, count = 0.
  - partial-word register, its keep bits and the last flag = 0.
  - m_valid = 0, m_data = 0, m_keep = 0, m_last = 0, s_ready = 1.
  - FIFO memory contents are don't-care.
  - Reset mid-line discards the partial word and all stored words.
- Packer:
  - On accept, s_data goes to lane = lane index and that lane's keep bit is set.
  - Commit condition: lane index = RATIO-1 or s_last = 1.
  - If commit: on the same edge, write {merged word, keep, s_last} to mem[wptr], increment wptr modulo DEPTH, reset lane index to 0, and clear the partial register and keep bits.
  - If no commit: lane index increments.
  - Lanes not written in a committed word are 0 with keep = 0. Keep bits are always a contiguous run from lane 0.
- s_ready = (count != DEPTH). It is never gated by m_ready; there is no write-through when full.
- Read side:
  - First-word-fall-through; head word read combinationally from mem[rptr].
  - m_valid = (count != 0). m_data/m_keep/m_last are driven to 0 when count = 0.
  - On a take, rptr increments modulo DEPTH.
- Latency: a word committed at edge N is visible on m_valid from just after edge N. There is no bypass while empty; a word committed at edge N cannot be taken before edge N+1.
- count:
  - +1 on commit only; -1 on take only; unchanged when both occur on the same edge.
  - Commit is impossible when full; take is impossible when empty.
- Pointers wrap silently at DEPTH. Full and empty are distinguished only by count.
- s_last with lane index 0 commits a 1-lane word (keep = 0…01).
- s_valid and s_last must not be X after reset. s_data and s_last are ignored when s_valid = 0.

Test Plan:
- Reset, then feed pixels 0x11,0x22,0x33,0x44 with m_ready = 1 (PIX_W=8, RATIO=4) -> one word 0x44332211, m_keep = 1111, m_last = 0; count returns to 0.
- Feed 0xA1,0xA2,0xA3 with s_last on 0xA3 -> word 0x00A3A2A1, m_keep = 0111, m_last = 1. A following single pixel 0x55 with s_last -> 0x00000055, keep = 0001.
- Hold m_ready = 0 and stream 64 pixels (DEPTH=16) -> count reaches 16 and s_ready drops after the 64th accept. Release m_ready -> 16 words come out in order with values intact, and s_ready reasserts one edge after the first take.
- At count = 8, commit and take on the same edge -> count stays 8 and data order is preserved. Run 100 words to exercise pointer wrap -> no loss or duplication.
- Assert rst_n low after 2 pixels of a word and with 5 words stored -> m_valid = 0 and count = 0 immediately. After release, the next 4 pixels form a clean word with no stale lanes.
- Random s_valid/m_ready at 50% duty over 2000 pixels with random s_last -> output matches a scoreboard model word-for-word, including keep and last.

Source files
------------

// File: rtl/pixel_pack_fifo.sv
// pixel_pack_fifo
//   Packs RATIO consecutive PIX_W pixels into one wide word (first pixel in
//   lane 0), stores packed words in a DEPTH-entry first-word-fall-through
//   FIFO and presents them on a valid/ready read port. s_last flushes a
//   partial word; m_keep marks the lanes that hold real pixels.
//
// Ports
//   clka     in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   s_valid  in   pixel valid
//   s_ready  out  room for another word (count != DEPTH)
//   s_data   in   pixel
//   s_last   in   final pixel of a line, qualified by s_valid
//   m_valid  out  head word available (count != 0)
//   m_ready  in   consumer takes head word
//   m_data   out  packed word, lane k at [k*PIX_W +: PIX_W]
//   m_keep   out  per-lane valid mask
//   m_last   out  head word ends a line
//   count    out  words held, 0..DEPTH
module pixel_pack_fifo #(
   parameter int PIX_W = 8,
   parameter int RATIO = 4,
   parameter int DEPTH = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clka,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [PIX_W-1:0]         s_data,
   input  logic                     s_last,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [PIX_W*RATIO-1:0]   m_data,
   output logic [RATIO-1:0]         m_keep,
   output logic                     m_last,
   output logic [ADDR_W:0]          count
);

   localparam int LANE_W = $clog2(RATIO);
   localparam int WORD_W = PIX_W * RATIO;

   logic [ADDR_W-1:0]  r_wptr;
   logic [ADDR_W-1:0]  r_rptr;
   logic [ADDR_W:0]    r_count;
   logic [LANE_W-1:0]  r_lane;
   logic [WORD_W-1:0]  r_part;
   logic [RATIO-1:0]   r_keep;

   logic [WORD_W-1:0]  r_mem_data [DEPTH];
   logic [RATIO-1:0]   r_mem_keep [DEPTH];
   logic               r_mem_last [DEPTH];

   logic               w_full;
   logic               w_empty;
   logic               w_accept;
   logic               w_commit;
   logic               w_take;
   logic [WORD_W-1:0]  w_word;
   logic [RATIO-1:0]   w_keep;

   assign w_full   = (r_count == (ADDR_W+1)'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_accept = s_valid & ~w_full;
   assign w_commit = w_accept & ((r_lane == LANE_W'(RATIO-1)) | s_last);
   // Take sees only words already stored: no bypass from the packer.
   assign w_take   = m_ready & ~w_empty;

   // Partial word merged with the incoming pixel in its lane.
   always_comb begin
      w_word = r_part;
      w_keep = r_keep;
      w_word[r_lane*PIX_W +: PIX_W] = s_data;
      w_keep[r_lane] = 1'b1;
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         r_lane <= '0;
         r_part <= '0;
         r_keep <= '0;
      end else if (w_accept) begin
         if (w_commit) begin
            r_lane <= '0;
            r_part <= '0;
            r_keep <= '0;
         end else begin
            r_lane <= r_lane + LANE_W'(1);
            r_part <= w_word;
            r_keep <= w_keep;
         end
      end
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_commit) r_wptr <= r_wptr + ADDR_W'(1);
         if (w_take)   r_rptr <= r_rptr + ADDR_W'(1);
         if (w_commit && !w_take)      r_count <= r_count + (ADDR_W+1)'(1);
         else if (w_take && !w_commit) r_count <= r_count - (ADDR_W+1)'(1);
      end
   end

   // Storage is not reset; entries are only visible once counted.
   always_ff @(posedge clka) begin
      if (w_commit) begin
         r_mem_data[r_wptr] <= w_word;
         r_mem_keep[r_wptr] <= w_keep;
         r_mem_last[r_wptr] <= s_last;
      end
   end

   assign s_ready = ~w_full;
   assign m_valid = ~w_empty;
   assign m_data  = w_empty ? '0   : r_mem_data[r_rptr];
   assign m_keep  = w_empty ? '0   : r_mem_keep[r_rptr];
   assign m_last  = w_empty ? 1'b0 : r_mem_last[r_rptr];
   assign count   = r_count;

endmodule

// File: tb/tb_pixel_pack_fifo.sv
module tb_pixel_pack_fifo;

   logic        clka = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        s_last;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic        m_last;
   logic [4:0]  count;

   pixel_pack_fifo #(.PIX_W(8), .RATIO(4), .DEPTH(16)) dut (
      .clka(clka), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
      .m_last(m_last), .count(count)
   );

   always #5 clka = ~clka;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } word_t;

   word_t      wq[$];
   logic [7:0] pq[$];
   int n_checks = 0;
   int n_errors = 0;
   int n_acc    = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_val("s_ready", 64'(s_ready), 64'(wq.size() != 16));
      check_val("m_valid", 64'(m_valid), 64'(wq.size() != 0));
      check_val("count",   64'(count),   64'(wq.size()));
      if (wq.size() != 0) begin
         check_val("m_data", 64'(m_data), 64'(wq[0].d));
         check_val("m_keep", 64'(m_keep), 64'(wq[0].k));
         check_val("m_last", 64'(m_last), 64'(wq[0].l));
      end else begin
         check_val("m_data0", 64'(m_data), 64'(0));
         check_val("m_keep0", 64'(m_keep), 64'(0));
         check_val("m_last0", 64'(m_last), 64'(0));
      end
   endtask

   // One clock: drive, check pre-edge outputs, clock, update the model.
   task automatic step(input logic v, input logic [7:0] d, input logic l, input logic mr);
      bit acc, take;
      word_t w;
      s_valid = v; s_data = d; s_last = l; m_ready = mr;
      #1;
      check_outputs();
      acc  = v && (wq.size() != 16);
      take = mr && (wq.size() != 0);
      @(posedge clka);
      if (take) void'(wq.pop_front());
      if (acc) begin
         n_acc++;
         pq.push_back(d);
         if (pq.size() == 4 || l) begin
            w.d = '0;
            for (int k = 0; k < pq.size(); k++) w.d |= 32'(pq[k]) << (8 * k);
            w.k = 4'((1 << pq.size()) - 1);
            w.l = l;
            wq.push_back(w);
            pq.delete();
         end
      end
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && wq.size() != 0; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
      #1;
      check_val("drain_cnt", 64'(count), 64'(0));
   endtask

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
      repeat (3) @(posedge clka);
      @(negedge clka) rst_n = 1'b1;
      @(posedge clka); #1;
      check_val("rst_m_valid", 64'(m_valid), 64'(0));
      check_val("rst_count",   64'(count),   64'(0));
      check_val("rst_s_ready", 64'(s_ready), 64'(1));
      check_val("rst_m_data",  64'(m_data),  64'(0));
      check_val("rst_m_keep",  64'(m_keep),  64'(0));
      check_val("rst_m_last",  64'(m_last),  64'(0));

      // Full word with consumer ready.
      step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
      check_val("pack_full", 64'(m_data), 64'h44332211);
      check_val("keep_full", 64'(m_keep), 64'hF);
      check_val("last_full", 64'(m_last), 64'h0);
      drain();

      // Flushed partial words.
      step(1, 8'hA1, 0, 0); step(1, 8'hA2, 0, 0); step(1, 8'hA3, 1, 0);
      check_val("pack_part", 64'(m_data), 64'h00A3A2A1);
      check_val("keep_part", 64'(m_keep), 64'h7);
      check_val("last_part", 64'(m_last), 64'h1);
      step(1, 8'h55, 1, 1);
      check_val("pack_one", 64'(m_data), 64'h00000055);
      check_val("keep_one", 64'(m_keep), 64'h1);
      drain();

      // Fill to full under backpressure, then release.
      for (int i = 0; i < 64; i++) step(1, 8'(i + 8'h40), 0, 0);
      check_val("full_cnt",   64'(count),   64'(16));
      check_val("full_ready", 64'(s_ready), 64'(0));
      step(1, 8'hEE, 0, 0);
      step(0, 8'h00, 0, 1);
      check_val("ready_back", 64'(s_ready), 64'(1));
      drain();

      // Simultaneous commit and take at count 8, then pointer wrap.
      for (int i = 0; i < 32; i++) step(1, 8'($urandom), 0, 0);
      step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0); step(1, 8'h03, 0, 0);
      step(1, 8'h04, 0, 1);
      check_val("cnt_same", 64'(count), 64'(8));
      for (int i = 0; i < 400; i++) step(1, 8'($urandom), 1'($urandom_range(0, 9) == 0), 1);
      drain();

      // Reset mid-line with stored words.
      for (int i = 0; i < 22; i++) step(1, 8'(i + 8'hC0), 0, 0);
      check_val("pre_rst_cnt", 64'(count), 64'(5));
      s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid", 64'(m_valid), 64'(0));
      check_val("mid_rst_count", 64'(count),   64'(0));
      wq.delete(); pq.delete();
      #2 rst_n = 1'b1;
      @(posedge clka); #1;
      step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0); step(1, 8'h03, 0, 0); step(1, 8'h04, 0, 0);
      check_val("post_rst_word", 64'(m_data), 64'h04030201);
      check_val("post_rst_keep", 64'(m_keep), 64'hF);
      drain();

      // Random traffic.
      n_acc = 0;
      for (int c = 0; c < 20000 && n_acc < 2000; c++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)));
      check_val("rand_accepts", 64'(n_acc >= 2000), 64'(1));
      if (pq.size() != 0) step(1, 8'h99, 1, 0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
